// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 serial link (transmitter and receiver).
// Holds the frame FSM encoding and the line-level constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   MIN_BIT_PERIOD = 2;

    // Bit periods below the minimum cannot be timed by a 1..P counter with
    // a one-clock look-ahead, so they are raised to the minimum.
    function automatic int unsigned clamp_period(input int unsigned period);
        return (period < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : period;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Programmable-rollover counter: counts 1..rollover_val and wraps back to 1.
// A synchronous clear restarts the count at 1, i.e. the first clock of a new period.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_reg;
    logic [NUM_CNT_BITS-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = NUM_CNT_BITS'(1);
        end else if (count_enable) begin
            if (count_reg == rollover_val) begin
                count_next = NUM_CNT_BITS'(1);
            end else begin
                count_next = count_reg + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_out     = count_reg;
    assign rollover_flag = (count_reg == rollover_val);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, DATA_BITS data bits LSB first, stop bit.
// tx_done is high during the last clock of the stop bit so a start request in that cycle chains the next frame with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int BP_BITS   = 14
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [BP_BITS-1:0]   bit_period,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BC_BITS = 4;

    tx_state_t              state_reg,      state_next;
    logic [DATA_BITS-1:0]   shreg_reg,      shreg_next;
    logic [BP_BITS-1:0]     period_reg,     period_next;
    logic                   serial_out_reg, serial_out_next;
    logic                   busy_reg,       busy_next;
    logic                   done_reg,       done_next;

    logic [DATA_BITS-1:0]   shreg_shifted;
    logic [BP_BITS-1:0]     period_clamped;
    logic [BP_BITS-1:0]     timer_count;
    logic                   timer_roll;
    logic [BC_BITS-1:0]     bit_count;
    logic                   bit_roll;
    logic                   accept;
    logic                   timer_enable;
    logic                   bit_enable;
    logic                   unused_bit_count;

    assign period_clamped = BP_BITS'(clamp_period(32'(bit_period)));

    // Right shift toward bit 0; the vacated MSB fills with the idle level.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_msb
                assign shreg_shifted[gi] = STOP_BIT;
            end else begin : g_mid
                assign shreg_shifted[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    // A new frame is taken from IDLE, or on the final stop-bit clock for back-to-back.
    assign accept = tx_start &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && timer_roll));

    assign timer_enable = (state_reg != IDLE);
    assign bit_enable   = (state_reg == DATA) && timer_roll;

    flex_counter #(
        .NUM_CNT_BITS (BP_BITS)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (accept),
        .count_enable  (timer_enable),
        .rollover_val  (period_reg),
        .count_out     (timer_count),
        .rollover_flag (timer_roll)
    );

    flex_counter #(
        .NUM_CNT_BITS (BC_BITS)
    ) u_bit_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (accept),
        .count_enable  (bit_enable),
        .rollover_val  (BC_BITS'(DATA_BITS)),
        .count_out     (bit_count),
        .rollover_flag (bit_roll)
    );

    // Frame position is tracked through bit_roll; the raw index is not needed here.
    assign unused_bit_count = ^bit_count;

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        period_next     = period_reg;
        serial_out_next = serial_out_reg;

        case (state_reg)
            IDLE: begin
                serial_out_next = STOP_BIT;
            end
            START: begin
                if (timer_roll) begin
                    state_next      = DATA;
                    serial_out_next = shreg_reg[0];
                end
            end
            DATA: begin
                if (timer_roll) begin
                    if (bit_roll) begin
                        state_next      = STOP;
                        serial_out_next = STOP_BIT;
                    end else begin
                        shreg_next      = shreg_shifted;
                        serial_out_next = shreg_shifted[0];
                    end
                end
            end
            STOP: begin
                if (timer_roll) begin
                    state_next      = IDLE;
                    serial_out_next = STOP_BIT;
                end
            end
            default: begin
                state_next      = IDLE;
                serial_out_next = STOP_BIT;
            end
        endcase

        if (accept) begin
            state_next      = START;
            shreg_next      = tx_data;
            period_next     = period_clamped;
            serial_out_next = START_BIT;
        end

        busy_next = (state_next != IDLE);
        // Period is at least 2, so count P-1 always precedes the final stop clock.
        done_next = (state_reg == STOP) && (timer_count == (period_reg - BP_BITS'(1)));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            period_reg     <= '0;
            serial_out_reg <= STOP_BIT;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            period_reg     <= period_next;
            serial_out_reg <= serial_out_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign serial_out = serial_out_reg;
    assign tx_busy    = busy_reg;
    assign tx_done    = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus a randomized receiver-style scoreboard.
// The expected line is derived from frame arithmetic: clock c of a frame carries bit (c-1)/P.
module tb_uart_tx;

    localparam int DB  = 8;
    localparam int BPB = 10;

    logic           clk        = 1'b0;
    logic           n_rst      = 1'b0;
    logic           tx_start   = 1'b0;
    logic [DB-1:0]  tx_data    = '0;
    logic [BPB-1:0] bit_period = '0;
    logic           serial_out;
    logic           tx_busy;
    logic           tx_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_BITS (DB),
        .BP_BITS   (BPB)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .bit_period (bit_period),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    function automatic int eff_period(input int bp);
        return (bp < 2) ? 2 : bp;
    endfunction

    // Line level at clock c (1-based, counted from the accepting edge).
    function automatic logic exp_line(input logic [7:0] d, input int p, input int c);
        int b;
        b = (c - 1) / p;
        if (b == 0) return 1'b0;
        if (b <= DB) return d[b-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        int bad;
        n_rst    = 1'b0;
        tx_start = 1'b0;
        #12;
        checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_line got=%b exp=1", serial_out); end
        checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        checks++; if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        @(negedge clk); n_rst = 1'b1;
        repeat (3) @(negedge clk);
        tx_data = 8'hA5; bit_period = 10; tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk); tx_start = 1'b0;
        repeat (40) @(negedge clk);
        // Clock 41 is data bit 3 of 8'hA5, which is 0.
        checks++; if (serial_out !== 1'b0 || tx_busy !== 1'b1) begin
            errors++; $display("FAIL pre_abort line=%b busy=%b exp line=0 busy=1", serial_out, tx_busy);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL abort_line got=%b exp=1", serial_out); end
        checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got=%b exp=0", tx_busy); end
        checks++; if (tx_done !== 1'b0)    begin errors++; $display("FAIL abort_done got=%b exp=0", tx_done); end
        @(negedge clk); n_rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL post_reset_idle bad_cycles=%0d exp=0", bad); end
        $display("test_reset: done");
    endtask

    task automatic test_single_frame();
        logic [9:0] bits;
        bits = '0;
        @(negedge clk);
        tx_data = 8'hA5; bit_period = 10; tx_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) tx_start = 1'b0;
            checks++; if (serial_out !== exp_line(8'hA5, 10, c)) begin
                errors++; $display("FAIL single_line c=%0d got=%b exp=%b", c, serial_out, exp_line(8'hA5, 10, c));
            end
            checks++; if (tx_done !== (c == 100)) begin
                errors++; $display("FAIL single_done c=%0d got=%b exp=%b", c, tx_done, (c == 100));
            end
            checks++; if (tx_busy !== 1'b1) begin
                errors++; $display("FAIL single_busy c=%0d got=%b exp=1", c, tx_busy);
            end
            if (((c - 1) % 10) == 5) bits[(c - 1) / 10] = serial_out;
        end
        checks++; if (bits !== 10'b1101001010) begin
            errors++; $display("FAIL single_bits got=%b exp=%b", bits, 10'b1101001010);
        end
        @(negedge clk);
        checks++; if (tx_busy !== 1'b0 || tx_done !== 1'b0 || serial_out !== 1'b1) begin
            errors++; $display("FAIL single_after busy=%b done=%b line=%b exp 0 0 1", tx_busy, tx_done, serial_out);
        end
        $display("test_single_frame: data=a5 P=10");
    endtask

    task automatic test_back_to_back();
        int line_bad;
        int busy_bad;
        int done_q[$];
        logic e;
        line_bad = 0; busy_bad = 0;
        @(negedge clk);
        tx_data = 8'h00; bit_period = 10; tx_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1)   tx_data  = 8'hFF;
            if (c == 101) tx_start = 1'b0;
            e = (c <= 100) ? exp_line(8'h00, 10, c) : exp_line(8'hFF, 10, c - 100);
            if (serial_out !== e) line_bad++;
            if (tx_busy !== 1'b1) busy_bad++;
            if (tx_done === 1'b1) done_q.push_back(c);
        end
        checks++; if (line_bad != 0) begin errors++; $display("FAIL b2b_line bad_cycles=%0d exp=0", line_bad); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b_busy bad_cycles=%0d exp=0", busy_bad); end
        checks++; if (done_q.size() != 2) begin
            errors++; $display("FAIL b2b_done_count got=%0d exp=2", done_q.size());
        end else begin
            checks++; if (done_q[0] != 100 || done_q[1] != 200) begin
                errors++; $display("FAIL b2b_done_pos got=%0d,%0d exp=100,200", done_q[0], done_q[1]);
            end
        end
        @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_after_busy got=%b exp=0", tx_busy); end
        $display("test_back_to_back: 00 then ff");
    endtask

    task automatic test_busy_drop();
        int line_bad;
        int done_cnt;
        int done_at;
        logic e;
        line_bad = 0; done_cnt = 0; done_at = -1;
        @(negedge clk);
        tx_data = 8'h3C; bit_period = 10; tx_start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (c == 1) tx_start = 1'b0;
            if (c == 35) begin tx_start = 1'b1; tx_data = 8'hC3; bit_period = 5; end
            if (c == 36) tx_start = 1'b0;
            e = (c <= 100) ? exp_line(8'h3C, 10, c) : 1'b1;
            if (serial_out !== e || tx_busy !== (c <= 100)) line_bad++;
            if (tx_done === 1'b1) begin done_cnt++; done_at = c; end
        end
        checks++; if (line_bad != 0) begin errors++; $display("FAIL busy_drop_line bad_cycles=%0d exp=0", line_bad); end
        checks++; if (done_cnt != 1 || done_at != 100) begin
            errors++; $display("FAIL busy_drop_done count=%0d at=%0d exp count=1 at=100", done_cnt, done_at);
        end
        $display("test_busy_drop: data=3c P=10");
    endtask

    task automatic test_period_bounds();
        int bps[3];
        bps[0] = 0; bps[1] = 1; bps[2] = (1 << BPB) - 1;
        for (int i = 0; i < 3; i++) begin
            int p;
            int flen;
            int line_bad;
            int done_at;
            logic [7:0] d;
            logic [7:0] rec;
            p = eff_period(bps[i]);
            flen = 10 * p;
            d = (i == 2) ? 8'h96 : 8'($urandom_range(0, 255));
            line_bad = 0; done_at = -1; rec = '0;
            @(negedge clk);
            tx_data = d; bit_period = BPB'(bps[i]); tx_start = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= flen + 3; c++) begin
                int b;
                @(negedge clk);
                if (c == 1) tx_start = 1'b0;
                if (c <= flen) begin
                    if (serial_out !== exp_line(d, p, c) || tx_busy !== 1'b1) line_bad++;
                end else begin
                    if (serial_out !== 1'b1 || tx_busy !== 1'b0) line_bad++;
                end
                b = (c - 1) / p;
                if (((c - 1) % p) == (p / 2) && b >= 1 && b <= DB) rec[b-1] = serial_out;
                if (tx_done === 1'b1) done_at = c;
            end
            checks++; if (line_bad != 0) begin
                errors++; $display("FAIL bound_line bp=%0d bad_cycles=%0d exp=0", bps[i], line_bad);
            end
            checks++; if (done_at != flen) begin
                errors++; $display("FAIL bound_done bp=%0d got=%0d exp=%0d", bps[i], done_at, flen);
            end
            checks++; if (rec !== d) begin
                errors++; $display("FAIL bound_byte bp=%0d got=%h exp=%h", bps[i], rec, d);
            end
            $display("test_period_bounds: bp=%0d data=%h frame=%0d clocks", bps[i], d, flen);
        end
    endtask

    task automatic test_scoreboard();
        int idle_bad;
        idle_bad = 0;
        for (int f = 0; f < 200; f++) begin
            int p;
            int gap;
            int line_bad;
            int done_at;
            logic [7:0] d;
            logic [7:0] rec;
            logic framing;
            d = 8'($urandom_range(0, 255));
            p = $urandom_range(2, 20);
            gap = $urandom_range(1, 3);
            line_bad = 0; done_at = -1; rec = '0; framing = 1'b1;
            @(negedge clk);
            tx_data = d; bit_period = BPB'(p); tx_start = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= 10 * p; c++) begin
                int b;
                @(negedge clk);
                if (c == 1) tx_start = 1'b0;
                if (c == 2) begin tx_data = ~d; bit_period = BPB'($urandom_range(0, 30)); end
                if (serial_out !== exp_line(d, p, c)) line_bad++;
                b = (c - 1) / p;
                if (((c - 1) % p) == (p / 2)) begin
                    if (b == 0 && serial_out !== 1'b0) framing = 1'b0;
                    else if (b == 9 && serial_out !== 1'b1) framing = 1'b0;
                    else if (b >= 1 && b <= DB) rec[b-1] = serial_out;
                end
                if (tx_done === 1'b1) done_at = c;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (tx_busy !== 1'b0 || serial_out !== 1'b1) idle_bad++;
            end
            checks++; if (rec !== d || !framing) begin
                errors++; $display("FAIL sb_byte frame=%0d got=%h framing=%b exp=%h", f, rec, framing, d);
            end
            checks++; if (line_bad != 0) begin
                errors++; $display("FAIL sb_line frame=%0d bad_cycles=%0d exp=0", f, line_bad);
            end
            checks++; if (done_at != 10 * p) begin
                errors++; $display("FAIL sb_done frame=%0d got=%0d exp=%0d", f, done_at, 10 * p);
            end
            $display("sb frame %0d: data=%h P=%0d recovered=%h", f, d, p, rec);
        end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL sb_idle_busy bad_cycles=%0d exp=0", idle_bad); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_drop();
        test_period_bounds();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
